// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: ROM address/data, redirect request, and the
// instruction output handshake.
interface fetch_sequencer_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_addr;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;

  // Sequencer side
  modport master (
    output mem_addr,
    input  mem_data,
    input  redirect,
    input  redirect_addr,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  // ROM / consumer / redirect-source side
  modport slave (
    input  mem_addr,
    output mem_data,
    output redirect,
    output redirect_addr,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues word addresses to a synchronous ROM,
// tracks the single read in flight, and buffers returned words in a 2-entry
// FIFO toward a valid/ready consumer. A redirect flushes everything and
// restarts fetch at the new address in the same cycle.
module fetch_sequencer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RESET_PC   = 0
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master bus
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_PC);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]            count_q, count_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  entry_t                fifo_q [2];

  logic                  vld;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [2:0]            occ;
  logic [ADDR_WIDTH-1:0] addr;
  entry_t                head;

  assign head = fifo_q[rd_ptr_q];
  // Outputs forced quiet while reset is held, even before the first edge clears count.
  assign vld           = (count_q != 2'd0) & ~rst;
  assign bus.out_valid = vld;
  assign bus.out_instr = vld ? head.instr : '0;
  assign bus.out_pc    = vld ? head.pc    : '0;
  assign bus.mem_addr  = addr;

  // Next-state: handshake decode, issue throttle and FIFO bookkeeping
  always_comb begin
    addr  = bus.redirect ? bus.redirect_addr : fetch_pc_q;
    pop   = vld & bus.out_ready & ~bus.redirect;
    push  = inflight_q & ~bus.redirect;
    // Slots already committed (queued + in flight) after this cycle's pop;
    // issuing only below 2 keeps the FIFO from ever overflowing.
    occ   = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    issue = bus.redirect | (occ < 3'd2);

    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (bus.redirect) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(push) - 2'(pop);
    end

    if (issue) begin
      inflight_pc_d = addr;
      fetch_pc_d    = addr + ADDR_WIDTH'(1);
    end
  end

  // Control state registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RST_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= 2'd0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // FIFO payload storage; contents are only observed through count, so no reset
  always_ff @(posedge clk) begin
    if (!rst && push) fifo_q[wr_ptr_q] <= '{instr: bus.mem_data, pc: inflight_pc_q};
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized + directed bench for fetch_sequencer against a transaction-level
// queue model: every issued address is a queue entry stamped with its issue
// cycle, and becomes visible at the head two cycles later.
module tb_fetch_sequencer;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam logic [AW-1:0] RPC = '0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fetch_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous ROM: ROM[i] = 0x1000 + i
  always @(posedge clk) bus.mem_data <= 32'h1000 + 32'(bus.mem_addr);

  typedef struct {
    logic [AW-1:0] pc;
    int            t;
  } ent_t;

  ent_t          mq[$];
  logic [AW-1:0] m_fpc = RPC;
  int            now = 0;
  int            nvec = 0;
  int            nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, now);
    end
  endtask

  function automatic bit m_valid();
    return (mq.size() > 0) && (mq[0].t <= now - 2);
  endfunction

  // One clock: drive inputs, check outputs against the model, advance model.
  task automatic step(input logic r, input logic rd, input logic [AW-1:0] ra, input logic rdy);
    bit            ev, pop, iss;
    logic [AW-1:0] a;
    @(negedge clk);
    rst               = r;
    bus.redirect      = rd;
    bus.redirect_addr = ra;
    bus.out_ready     = rdy;
    #1;
    if (r) begin
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_pc",    32'(bus.out_pc),    32'd0);
      chk("rst_instr", bus.out_instr,      32'd0);
      mq.delete();
      m_fpc = RPC;
    end else begin
      ev = m_valid();
      a  = rd ? ra : m_fpc;
      chk("valid",    32'(bus.out_valid), 32'(ev));
      chk("mem_addr", 32'(bus.mem_addr),  32'(a));
      if (ev) begin
        chk("out_pc",    32'(bus.out_pc), 32'(mq[0].pc));
        chk("out_instr", bus.out_instr,   32'h1000 + 32'(mq[0].pc));
      end
      pop = ev && rdy && !rd;
      if (rd) mq.delete();
      iss = rd || ((mq.size() - int'(pop)) < 2);
      if (pop) void'(mq.pop_front());
      if (iss) begin
        mq.push_back('{pc: a, t: now});
        m_fpc = a + AW'(1);
      end
    end
    now++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    int  waited;
    bit  found;
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_addr = '0;
    bus.out_ready = 1'b0;

    // Reset release, streaming with ready held high
    do_reset(3);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Backpressure: consumer stalls 10 cycles, then drains
    do_reset(1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b0);
    chk("stall_addr", 32'(bus.mem_addr), 32'd2);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Redirect to 0x200 while the head is pc 5
    do_reset(1);
    found = 1'b0;
    for (waited = 0; waited < 20 && !found; waited++) begin
      if (m_valid() && mq[0].pc == AW'(5)) found = 1'b1;
      else step(1'b0, 1'b0, '0, 1'b1);
    end
    chk("reach_pc5", 32'(found), 32'd1);
    step(1'b0, 1'b1, AW'(10'h200), 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Wrap-around from 0x3FE
    step(1'b0, 1'b1, AW'(10'h3FE), 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Back-to-back redirects: only the last target survives
    step(1'b0, 1'b1, AW'(10'h010), 1'b1);
    step(1'b0, 1'b1, AW'(10'h020), 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Reset with FIFO full and a read in flight
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b0);
    do_reset(1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99) < 2),
           ($urandom_range(99) < 6),
           AW'($urandom),
           ($urandom_range(99) < 70));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set the instruction word-address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the instruction width.
REQ-003 Parameter RESET_PC, default 0, SHALL set the first fetch address after reset.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 mem_addr  output  ADDR_WIDTH  SHALL be the word address driven to the synchronous instruction ROM, combinational.
REQ-007 mem_data  input  DATA_WIDTH  SHALL be the ROM read data, valid one cycle after the address was issued.
REQ-008 redirect  input  1  SHALL request a flush and a restart of fetch at redirect_addr.
REQ-009 redirect_addr  input  ADDR_WIDTH  SHALL be the restart address, sampled when redirect=1.
REQ-010 out_valid  output  1  SHALL flag a valid instruction at the queue head.
REQ-011 out_ready  input  1  SHALL indicate that the consumer accepts the head this cycle.
REQ-012 out_instr  output  DATA_WIDTH  SHALL be the head instruction.
REQ-013 out_pc  output  ADDR_WIDTH  SHALL be the word address of out_instr.

Function
REQ-014 State SHALL comprise fetch_pc, a 1-entry in-flight tracker (inflight, inflight_pc), and a 2-entry FIFO of {instr, pc} with count 0..2.
REQ-015 pop SHALL equal out_valid & out_ready & ~redirect.
REQ-016 issue SHALL be 1 when redirect=1, else when count + inflight - pop < 2.
REQ-017 mem_addr SHALL equal redirect_addr when redirect=1, else fetch_pc.
REQ-018 On issue, inflight SHALL be set next cycle with inflight_pc = mem_addr, and fetch_pc SHALL become mem_addr + 1 modulo 2**ADDR_WIDTH (0x3FF wraps to 0x000).
REQ-019 When no issue occurs, inflight SHALL clear next cycle and fetch_pc SHALL hold.
REQ-020 When inflight=1 and redirect=0, {mem_data, inflight_pc} SHALL be written into the FIFO tail that cycle.
REQ-021 A FIFO push and pop in the same cycle SHALL leave count unchanged and preserve order; the FIFO SHALL never overflow, and REQ-016 guarantees this.
REQ-022 out_valid SHALL equal (count != 0); out_instr and out_pc SHALL reflect the head entry and hold stable while out_valid=1 and pop=0.
REQ-023 out_ready with out_valid=0 SHALL have no effect.
REQ-024 On redirect=1: the FIFO SHALL empty, the in-flight response arriving that cycle SHALL be discarded, the head SHALL not be popped, and a fetch at redirect_addr SHALL issue that same cycle.
REQ-025 Latency: an address issued in cycle T SHALL appear at the head (out_valid=1) in cycle T+2 when the FIFO was empty.
REQ-026 Throughput: with out_ready held at 1 and no redirect, out_valid SHALL stay at 1 every cycle after the initial latency, with out_pc incrementing by 1 per cycle.
REQ-027 A redirect asserted on consecutive cycles SHALL honour the last one; earlier targets SHALL never reach the output.

Reset
REQ-028 While rst=1: count=0, inflight=0, fetch_pc=RESET_PC, out_valid=0; out_instr and out_pc SHALL read 0; no push occurs.
REQ-029 rst SHALL take priority over redirect and all handshakes, and reset mid-stream SHALL discard all queued and in-flight words.
REQ-030 In the first cycle with rst=0, mem_addr SHALL equal RESET_PC and an issue SHALL occur; out_valid SHALL rise two cycles later.

Verification
REQ-031 Reset release, out_ready=1, ROM[i]=0x1000+i -> out_valid from cycle 2; (out_pc, out_instr) = (0,0x1000), (1,0x1001), (2,0x1002)... one per cycle with no bubbles.
REQ-032 out_ready=0 for 10 cycles after start -> count saturates at 2, issue stops, mem_addr holds at 2; out_ready=1 -> pcs 0,1,2,3 delivered in order with no loss or duplication.
REQ-033 Redirect to 0x200 in the cycle the head is pc 5 with out_ready=1 -> pc 5 not consumed; next valid output is (0x200, ROM[0x200]) two cycles later; pcs 6 and 7 are never output.
REQ-034 Redirect to 0x3FE with out_ready=1 -> outputs pc 0x3FE, 0x3FF, 0x000, 0x001 (wrap-around).
REQ-035 Redirect to 0x10 then 0x20 on back-to-back cycles -> first output is pc 0x20, and 0x10 never appears.
REQ-036 rst asserted for 1 cycle while the FIFO is full and a read is in flight -> out_valid=0 next cycle; stream restarts at RESET_PC with 2-cycle latency.
